// File: rtl/ae_matrix_line_ctrl.sv
// Line-buffer sequencer for the AE 5x5 window: tracks x/y from vsync/href, drives the
// shared line-RAM enable/address, and appends synthetic flush lines after each frame.
module ae_matrix_line_ctrl #(
    parameter int IMG_HDISP   = 1280,
    parameter int IMG_VDISP   = 720,
    parameter int ADDR_W      = 11,
    parameter int FLUSH_LINES = 2,
    parameter int HBLANK      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              per_frame_vsync,
    input  logic              per_frame_href,
    output logic              ram_clken,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [11:0]       y_cnt,
    output logic [2:0]        col_code,
    output logic [2:0]        row_code,
    output logic              win_valid,
    output logic              flush_active,
    output logic              frame_done,
    output logic              err_line,
    output logic              err_frame
);

    // x must be able to hold IMG_HDISP itself so over-long lines are detected without wrapping
    localparam int XW = $clog2(IMG_HDISP + 1);
    localparam int GW = (HBLANK > 1) ? $clog2(HBLANK) : 1;

    localparam logic [XW-1:0] X_END   = XW'(IMG_HDISP);
    localparam logic [XW-1:0] X_LAST  = XW'(IMG_HDISP - 1);
    localparam logic [XW-1:0] X_PENUL = XW'(IMG_HDISP - 2);
    localparam logic [11:0]   Y_V     = 12'(IMG_VDISP);
    localparam logic [11:0]   Y_V1    = 12'(IMG_VDISP + 1);
    localparam logic [11:0]   Y_END   = 12'(IMG_VDISP + FLUSH_LINES);
    localparam logic [GW-1:0] G_LAST  = GW'(HBLANK - 1);

    localparam logic [2:0] CODE_MID = 3'd0;
    localparam logic [2:0] CODE_E2  = 3'd1;
    localparam logic [2:0] CODE_E1  = 3'd2;
    localparam logic [2:0] CODE_F1  = 3'd3;
    localparam logic [2:0] CODE_F2  = 3'd4;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_LINE  = 3'd1,
        LINE       = 3'd2,
        FLUSH_GAP  = 3'd3,
        FLUSH_LINE = 3'd4
    } state_t;

    state_t          state_reg;
    logic [XW-1:0]   x_reg;
    logic [GW-1:0]   gap_reg;
    logic            vsync_reg;

    logic            vsync_rise;
    logic            issue_en;
    logic [11:0]     y_inc;
    logic [2:0]      col_next;
    logic [2:0]      row_next;

    assign vsync_rise = per_frame_vsync & ~vsync_reg;
    assign y_inc      = y_cnt + 12'd1;

    // A pixel is issued this cycle; a vsync rise pre-empts everything as a frame restart
    always_comb begin
        issue_en = 1'b0;
        if (!vsync_rise) begin
            case (state_reg)
                WAIT_LINE:  issue_en = per_frame_vsync & per_frame_href;
                LINE:       issue_en = per_frame_href & (x_reg < X_END);
                FLUSH_LINE: issue_en = 1'b1;
                default:    issue_en = 1'b0;
            endcase
        end
    end

    always_comb begin
        col_next = CODE_MID;
        if (x_reg == '0)
            col_next = CODE_E2;
        else if (x_reg == XW'(1))
            col_next = CODE_E1;
        else if (x_reg == X_PENUL)
            col_next = CODE_F1;
        else if (x_reg == X_LAST)
            col_next = CODE_F2;
    end

    // Window centre row is y_cnt-2, so compare y_cnt against offset positions directly
    always_comb begin
        row_next = CODE_MID;
        if (y_cnt == 12'd2)
            row_next = CODE_E2;
        else if (y_cnt == 12'd3)
            row_next = CODE_E1;
        else if (y_cnt == Y_V)
            row_next = CODE_F1;
        else if (y_cnt == Y_V1)
            row_next = CODE_F2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            x_reg        <= '0;
            gap_reg      <= '0;
            vsync_reg    <= 1'b0;
            y_cnt        <= '0;
            ram_clken    <= 1'b0;
            ram_addr     <= '0;
            col_code     <= CODE_MID;
            row_code     <= CODE_MID;
            win_valid    <= 1'b0;
            flush_active <= 1'b0;
            frame_done   <= 1'b0;
            err_line     <= 1'b0;
            err_frame    <= 1'b0;
        end else begin
            vsync_reg  <= per_frame_vsync;
            ram_clken  <= issue_en;
            win_valid  <= issue_en && (y_cnt >= 12'd2);
            frame_done <= 1'b0;
            if (issue_en) begin
                ram_addr <= ADDR_W'(x_reg);
                col_code <= col_next;
                row_code <= row_next;
            end

            if (vsync_rise) begin
                state_reg    <= WAIT_LINE;
                x_reg        <= '0;
                gap_reg      <= '0;
                y_cnt        <= '0;
                err_line     <= 1'b0;
                err_frame    <= 1'b0;
                flush_active <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        x_reg <= '0;
                    end
                    WAIT_LINE: begin
                        if (!per_frame_vsync) begin
                            if (y_cnt < Y_V)
                                err_frame <= 1'b1;
                            state_reg <= IDLE;
                        end else if (per_frame_href) begin
                            x_reg     <= XW'(1);
                            state_reg <= LINE;
                        end
                    end
                    LINE: begin
                        if (per_frame_href) begin
                            if (x_reg < X_END)
                                x_reg <= x_reg + XW'(1);
                            else
                                err_line <= 1'b1;
                        end else begin
                            if (x_reg != X_END)
                                err_line <= 1'b1;
                            x_reg <= '0;
                            y_cnt <= y_inc;
                            if (y_inc == Y_V) begin
                                state_reg    <= FLUSH_GAP;
                                flush_active <= 1'b1;
                            end else begin
                                state_reg <= WAIT_LINE;
                            end
                        end
                    end
                    FLUSH_GAP: begin
                        if (per_frame_href)
                            err_frame <= 1'b1;
                        if (gap_reg == G_LAST) begin
                            gap_reg   <= '0;
                            state_reg <= FLUSH_LINE;
                        end else begin
                            gap_reg <= gap_reg + GW'(1);
                        end
                    end
                    FLUSH_LINE: begin
                        if (per_frame_href)
                            err_frame <= 1'b1;
                        if (x_reg == X_LAST) begin
                            x_reg <= '0;
                            y_cnt <= y_inc;
                            if (y_inc == Y_END) begin
                                frame_done   <= 1'b1;
                                flush_active <= 1'b0;
                                state_reg    <= IDLE;
                            end else begin
                                state_reg <= FLUSH_GAP;
                            end
                        end else begin
                            x_reg <= x_reg + XW'(1);
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ae_matrix_line_ctrl.sv
// Directed bench for ae_matrix_line_ctrl with H=8, V=6, FLUSH_LINES=2, HBLANK=4.
module tb_ae_matrix_line_ctrl;

    localparam int H  = 8;
    localparam int V  = 6;
    localparam int AW = 3;
    localparam int FL = 2;
    localparam int HB = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          vsync = 1'b0;
    logic          href = 1'b0;
    logic          ram_clken;
    logic [AW-1:0] ram_addr;
    logic [11:0]   y_cnt;
    logic [2:0]    col_code;
    logic [2:0]    row_code;
    logic          win_valid;
    logic          flush_active;
    logic          frame_done;
    logic          err_line;
    logic          err_frame;

    ae_matrix_line_ctrl #(
        .IMG_HDISP(H), .IMG_VDISP(V), .ADDR_W(AW), .FLUSH_LINES(FL), .HBLANK(HB)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .per_frame_vsync(vsync), .per_frame_href(href),
        .ram_clken(ram_clken), .ram_addr(ram_addr), .y_cnt(y_cnt),
        .col_code(col_code), .row_code(row_code), .win_valid(win_valid),
        .flush_active(flush_active), .frame_done(frame_done),
        .err_line(err_line), .err_frame(err_frame)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int clk_cnt = 0, win_cnt = 0, done_cnt = 0, flush_cnt = 0;
    int addr_q[$];
    int col_q[$];
    int row_q[$];

    // Observes registered outputs on the falling edge
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (ram_clken) begin
                clk_cnt++;
                addr_q.push_back(int'(ram_addr));
                col_q.push_back(int'(col_code));
                row_q.push_back(int'(row_code));
                if (win_valid) win_cnt++;
            end
            if (frame_done) done_cnt++;
            if (flush_active) flush_cnt++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_mon();
        #2;
        clk_cnt = 0; win_cnt = 0; done_cnt = 0; flush_cnt = 0;
        addr_q.delete(); col_q.delete(); row_q.delete();
    endtask

    task automatic start_frame();
        @(negedge clk);
        vsync = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic drive_line(input int len);
        for (int i = 0; i < len; i++) begin
            href = 1'b1;
            @(negedge clk);
        end
        href = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic end_frame();
        for (int i = 0; i < 200 && done_cnt == 0; i++) @(negedge clk);
        n_cmp++;
        if (done_cnt == 0) begin n_bad++; $display("FAIL frame_done_timeout: got no pulse within 200 cycles, want a pulse"); end
        vsync = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; vsync = 1'b0; href = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({ram_clken, win_valid, flush_active, frame_done, err_line, err_frame} !== 6'b0) begin
            n_bad++; $display("FAIL reset_flags: got %b want 000000", {ram_clken, win_valid, flush_active, frame_done, err_line, err_frame});
        end
        n_cmp++;
        if (y_cnt !== 12'd0) begin n_bad++; $display("FAIL reset_y_cnt: got %0d want 0", y_cnt); end
        n_cmp++;
        if ({ram_addr, col_code, row_code} !== 9'd0) begin
            n_bad++; $display("FAIL reset_addr_codes: got %0h want 0", {ram_addr, col_code, row_code});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_latency();
        start_frame();
        href = 1'b1;
        n_cmp++;
        if (ram_clken !== 1'b0) begin n_bad++; $display("FAIL lat_before: got clken=%b want 0", ram_clken); end
        @(negedge clk);
        n_cmp++;
        if (ram_clken !== 1'b1) begin n_bad++; $display("FAIL lat_clken: got %b want 1", ram_clken); end
        n_cmp++;
        if (ram_addr !== 3'd0) begin n_bad++; $display("FAIL lat_addr: got %0d want 0", ram_addr); end
        n_cmp++;
        if (col_code !== 3'd1) begin n_bad++; $display("FAIL lat_col: got %0d want 1", col_code); end
        n_cmp++;
        if (win_valid !== 1'b0) begin n_bad++; $display("FAIL lat_win: got %b want 0", win_valid); end
        href = 1'b0;
        repeat (2) @(negedge clk);
        vsync = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({err_line, err_frame} !== 2'b11) begin
            n_bad++; $display("FAIL lat_errs: got line=%b frame=%b want 1 1", err_line, err_frame);
        end
    endtask

    task automatic test_clean_frame();
        clear_mon();
        start_frame();
        for (int l = 0; l < V; l++) drive_line(H);
        end_frame();
        n_cmp++;
        if (clk_cnt != 64) begin n_bad++; $display("FAIL clean_clken: got %0d want 64", clk_cnt); end
        n_cmp++;
        if (done_cnt != 1) begin n_bad++; $display("FAIL clean_done: got %0d want 1", done_cnt); end
        n_cmp++;
        if (flush_cnt != 24) begin n_bad++; $display("FAIL clean_flush_cycles: got %0d want 24", flush_cnt); end
        n_cmp++;
        if (win_cnt != 48) begin n_bad++; $display("FAIL clean_win: got %0d want 48", win_cnt); end
        n_cmp++;
        if (y_cnt !== 12'd8) begin n_bad++; $display("FAIL clean_y_cnt: got %0d want 8", y_cnt); end
        n_cmp++;
        if ({err_line, err_frame} !== 2'b00) begin
            n_bad++; $display("FAIL clean_errs: got line=%b frame=%b want 0 0", err_line, err_frame);
        end
        for (int i = 0; i < addr_q.size(); i++) begin
            n_cmp++;
            if (addr_q[i] != i % H) begin n_bad++; $display("FAIL clean_addr[%0d]: got %0d want %0d", i, addr_q[i], i % H); end
        end
    endtask

    // Uses the pixel log captured by test_clean_frame
    task automatic test_codes();
        int col_tab[8] = '{1, 2, 0, 0, 0, 0, 3, 4};
        int row_tab[8] = '{0, 0, 1, 2, 0, 0, 3, 4};
        n_cmp++;
        if (col_q.size() != 64) begin n_bad++; $display("FAIL codes_len: got %0d want 64", col_q.size()); end
        for (int i = 0; i < col_q.size() && i < 64; i++) begin
            n_cmp++;
            if (col_q[i] != col_tab[i % 8]) begin n_bad++; $display("FAIL col_code[%0d]: got %0d want %0d", i, col_q[i], col_tab[i % 8]); end
            n_cmp++;
            if (row_q[i] != row_tab[i / 8]) begin n_bad++; $display("FAIL row_code[%0d]: got %0d want %0d", i, row_q[i], row_tab[i / 8]); end
        end
    endtask

    task automatic test_short_line();
        clear_mon();
        start_frame();
        drive_line(H);
        drive_line(H);
        n_cmp++;
        if (err_line !== 1'b0) begin n_bad++; $display("FAIL short_pre_err: got %b want 0", err_line); end
        drive_line(6);
        n_cmp++;
        if (err_line !== 1'b1) begin n_bad++; $display("FAIL short_err_line: got %b want 1", err_line); end
        n_cmp++;
        if (y_cnt !== 12'd3) begin n_bad++; $display("FAIL short_y_cnt: got %0d want 3", y_cnt); end
        for (int l = 3; l < V; l++) drive_line(H);
        end_frame();
        n_cmp++;
        if (clk_cnt != 62) begin n_bad++; $display("FAIL short_clken: got %0d want 62", clk_cnt); end
        n_cmp++;
        if (done_cnt != 1) begin n_bad++; $display("FAIL short_done: got %0d want 1", done_cnt); end
        n_cmp++;
        if (y_cnt !== 12'd8) begin n_bad++; $display("FAIL short_y_end: got %0d want 8", y_cnt); end
        n_cmp++;
        if (err_frame !== 1'b0) begin n_bad++; $display("FAIL short_err_frame: got %b want 0", err_frame); end
    endtask

    task automatic test_long_line();
        clear_mon();
        start_frame();
        drive_line(H);
        drive_line(10);
        for (int l = 2; l < V; l++) drive_line(H);
        end_frame();
        n_cmp++;
        if (clk_cnt != 64) begin n_bad++; $display("FAIL long_clken: got %0d want 64", clk_cnt); end
        n_cmp++;
        if (err_line !== 1'b1) begin n_bad++; $display("FAIL long_err_line: got %b want 1", err_line); end
        n_cmp++;
        if (done_cnt != 1) begin n_bad++; $display("FAIL long_done: got %0d want 1", done_cnt); end
        for (int i = 0; i < addr_q.size(); i++) begin
            n_cmp++;
            if (addr_q[i] != i % H) begin n_bad++; $display("FAIL long_addr[%0d]: got %0d want %0d", i, addr_q[i], i % H); end
        end
    endtask

    task automatic test_vsync_early();
        clear_mon();
        start_frame();
        for (int l = 0; l < 3; l++) drive_line(H);
        vsync = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (err_frame !== 1'b1) begin n_bad++; $display("FAIL early_err_frame: got %b want 1", err_frame); end
        n_cmp++;
        if (y_cnt !== 12'd3) begin n_bad++; $display("FAIL early_y_cnt: got %0d want 3", y_cnt); end
        n_cmp++;
        if (done_cnt != 0) begin n_bad++; $display("FAIL early_done: got %0d want 0", done_cnt); end
        n_cmp++;
        if (flush_active !== 1'b0) begin n_bad++; $display("FAIL early_flush: got %b want 0", flush_active); end
        drive_line(4);
        n_cmp++;
        if (clk_cnt != 24) begin n_bad++; $display("FAIL early_idle_clken: got %0d want 24", clk_cnt); end
    endtask

    task automatic test_href_in_flush();
        clear_mon();
        start_frame();
        for (int l = 0; l < V; l++) drive_line(H);
        href = 1'b1;
        repeat (2) @(negedge clk);
        href = 1'b0;
        end_frame();
        n_cmp++;
        if (err_frame !== 1'b1) begin n_bad++; $display("FAIL flushhref_err_frame: got %b want 1", err_frame); end
        n_cmp++;
        if (clk_cnt != 64) begin n_bad++; $display("FAIL flushhref_clken: got %0d want 64", clk_cnt); end
        n_cmp++;
        if (done_cnt != 1) begin n_bad++; $display("FAIL flushhref_done: got %0d want 1", done_cnt); end
        n_cmp++;
        if (err_line !== 1'b0) begin n_bad++; $display("FAIL flushhref_err_line: got %b want 0", err_line); end
    endtask

    task automatic test_restart();
        bit seen;
        clear_mon();
        start_frame();
        drive_line(5);
        for (int l = 1; l < V; l++) drive_line(H);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = ram_clken && flush_active;
        end
        n_cmp++;
        if (!seen) begin n_bad++; $display("FAIL restart_flush_timeout: got no flush pixel within 100 cycles, want one"); end
        vsync = 1'b0;
        @(negedge clk);
        vsync = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({err_line, err_frame} !== 2'b00) begin
            n_bad++; $display("FAIL restart_errs: got line=%b frame=%b want 0 0", err_line, err_frame);
        end
        n_cmp++;
        if (y_cnt !== 12'd0) begin n_bad++; $display("FAIL restart_y_cnt: got %0d want 0", y_cnt); end
        n_cmp++;
        if ({flush_active, ram_clken} !== 2'b00) begin
            n_bad++; $display("FAIL restart_flush_clken: got %b want 00", {flush_active, ram_clken});
        end
        clear_mon();
        drive_line(H);
        n_cmp++;
        if (clk_cnt != H) begin n_bad++; $display("FAIL restart_clken: got %0d want %0d", clk_cnt, H); end
        for (int i = 0; i < addr_q.size(); i++) begin
            n_cmp++;
            if (addr_q[i] != i) begin n_bad++; $display("FAIL restart_addr[%0d]: got %0d want %0d", i, addr_q[i], i); end
        end
        n_cmp++;
        if (y_cnt !== 12'd1) begin n_bad++; $display("FAIL restart_y_after: got %0d want 1", y_cnt); end
        n_cmp++;
        if (done_cnt != 0) begin n_bad++; $display("FAIL restart_done: got %0d want 0", done_cnt); end
        vsync = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_async_reset();
        start_frame();
        href = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (ram_clken !== 1'b0) begin n_bad++; $display("FAIL async_clken: got %b want 0", ram_clken); end
        n_cmp++;
        if (ram_addr !== 3'd0) begin n_bad++; $display("FAIL async_addr: got %0d want 0", ram_addr); end
        href = 1'b0;
        vsync = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_latency();
        test_clean_frame();
        test_codes();
        test_short_line();
        test_long_line();
        test_vsync_early();
        test_href_in_flush();
        test_restart();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
